// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file constants used by the register file and its writeback arbiter.
package regfile_wb_arbiter_pkg;

   localparam int RF_ADDR_W = 5;
   localparam int RF_DATA_W = 32;
   localparam int RF_GID_W  = 2;

   localparam logic [RF_ADDR_W-1:0] RF_ZERO_REG = 5'd0;

endpackage

// File: rtl/regfile_wb_arbiter_rr_pick.sv
// Combinational round-robin picker: the first requester after last_grant (modulo N) wins.
module regfile_wb_arbiter_rr_pick #(
   parameter int N     = 2,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] last_grant,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_any
);

   logic found_s;
   logic hit_s;

   // Walk offsets 1..N from last_grant; each offset selects exactly one candidate.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found_s = 1'b0;
      hit_s   = 1'b0;
      for (int i = 1; i <= N; i++) begin
         for (int k = 0; k < N; k++) begin
            hit_s   = req[k] & ~found_s & (((int'(last_grant) + i) % N) == k);
            gnt[k]  = gnt[k] | hit_s;
            gnt_idx = hit_s ? IDX_W'(k) : gnt_idx;
            found_s = found_s | hit_s;
         end
      end
      gnt_any = found_s;
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_SRC writeback sources,
// with a registered write stage and an accepted-writeback counter.
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int NUM_SRC = 2,
   parameter int ADDR_W  = RF_ADDR_W,
   parameter int DATA_W  = RF_DATA_W,
   parameter int CNT_W   = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic [NUM_SRC-1:0]        src_valid,
   input  logic [NUM_SRC*ADDR_W-1:0] src_rd,
   input  logic [NUM_SRC*DATA_W-1:0] src_data,
   output logic [NUM_SRC-1:0]        src_ready,
   output logic                      rf_we,
   output logic [ADDR_W-1:0]         rf_waddr,
   output logic [DATA_W-1:0]         rf_wdata,
   output logic [RF_GID_W-1:0]       grant_id,
   output logic [CNT_W-1:0]          wb_count
);

   logic [RF_GID_W-1:0] last_grant_q, last_grant_d;
   logic                rf_we_q,      rf_we_d;
   logic [ADDR_W-1:0]   rf_waddr_q,   rf_waddr_d;
   logic [DATA_W-1:0]   rf_wdata_q,   rf_wdata_d;
   logic [RF_GID_W-1:0] grant_id_q,   grant_id_d;
   logic [CNT_W-1:0]    wb_count_q,   wb_count_d;

   logic [NUM_SRC-1:0]  pick_gnt_s;
   logic [RF_GID_W-1:0] pick_idx_s;
   logic                pick_any_s;
   logic                xfer_s;
   logic [ADDR_W-1:0]   sel_rd_s;
   logic [DATA_W-1:0]   sel_data_s;

   regfile_wb_arbiter_rr_pick #(
      .N     (NUM_SRC),
      .IDX_W (RF_GID_W)
   ) u_pick (
      .req        (src_valid),
      .last_grant (last_grant_q),
      .gnt        (pick_gnt_s),
      .gnt_idx    (pick_idx_s),
      .gnt_any    (pick_any_s)
   );

   // Grant gating, one-hot payload select and next-state of the write stage.
   always_comb begin
      src_ready    = (rst | flush) ? '0 : pick_gnt_s;
      xfer_s       = pick_any_s & ~rst & ~flush;
      sel_rd_s     = '0;
      sel_data_s   = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         sel_rd_s   = pick_gnt_s[k] ? src_rd[k*ADDR_W +: ADDR_W]   : sel_rd_s;
         sel_data_s = pick_gnt_s[k] ? src_data[k*DATA_W +: DATA_W] : sel_data_s;
      end
      last_grant_d = last_grant_q;
      rf_waddr_d   = rf_waddr_q;
      rf_wdata_d   = rf_wdata_q;
      grant_id_d   = grant_id_q;
      wb_count_d   = wb_count_q;
      rf_we_d      = 1'b0;
      if (xfer_s) begin
         last_grant_d = pick_idx_s;
         grant_id_d   = pick_idx_s;
         rf_waddr_d   = sel_rd_s;
         rf_wdata_d   = sel_data_s;
         wb_count_d   = wb_count_q + CNT_W'(1);
         // x0 writes are consumed and counted but never reach the register file.
         rf_we_d      = (sel_rd_s != ADDR_W'(RF_ZERO_REG));
      end else begin
         rf_we_d      = 1'b0;
      end
   end

   // State registers; reset starts the pointer at the last source so source 0 wins first.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q <= RF_GID_W'(NUM_SRC - 1);
         rf_we_q      <= 1'b0;
         rf_waddr_q   <= '0;
         rf_wdata_q   <= '0;
         grant_id_q   <= '0;
         wb_count_q   <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         rf_we_q      <= rf_we_d;
         rf_waddr_q   <= rf_waddr_d;
         rf_wdata_q   <= rf_wdata_d;
         grant_id_q   <= grant_id_d;
         wb_count_q   <= wb_count_d;
      end
   end

   assign rf_we    = rf_we_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;
   assign grant_id = grant_id_q;
   assign wb_count = wb_count_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a round-robin reference model pushes expected
// writes to a scoreboard that is popped when the registered write appears.
module tb_regfile_wb_arbiter;

   localparam int NS = 2;

   typedef struct packed {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [1:0]  gid;
   } exp_t;

   logic          clk;
   logic          rst;
   logic          flush;
   logic [1:0]    src_valid;
   logic [9:0]    src_rd;
   logic [63:0]   src_data;
   logic [1:0]    src_ready;
   logic          rf_we;
   logic [4:0]    rf_waddr;
   logic [31:0]   rf_wdata;
   logic [1:0]    grant_id;
   logic [31:0]   wb_count;

   logic [31:0]   rf_mem [0:31];
   exp_t          sb [$];
   int            n_pass;
   int            n_total;
   int            m_last;
   int            m_count;

   regfile_wb_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .src_valid (src_valid),
      .src_rd    (src_rd),
      .src_data  (src_data),
      .src_ready (src_ready),
      .rf_we     (rf_we),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .grant_id  (grant_id),
      .wb_count  (wb_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Simple register-file model fed by the arbiter's write port.
   always @(posedge clk) begin
      if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic do_reset(input int cycles, input logic [1:0] v);
      @(negedge clk);
      rst = 1'b1; flush = 1'b0; src_valid = v;
      src_rd = {5'd3, 5'd4}; src_data = {32'h11111111, 32'h22222222};
      for (int c = 0; c < cycles; c++) begin
         #1;
         chk("ready_in_reset", src_ready, 2'b00);
         @(posedge clk); #1;
      end
      sb.delete();
      m_last  = NS - 1;
      m_count = 0;
      chk("rst_we", rf_we, 1'b0);
      chk("rst_waddr", rf_waddr, 5'd0);
      chk("rst_wdata", rf_wdata, 32'd0);
      chk("rst_gid", grant_id, 2'd0);
      chk("rst_count", wb_count, 32'd0);
      @(negedge clk);
      rst = 1'b0; src_valid = 2'b00;
   endtask

   task automatic step(input string tag, input logic [1:0] v, input logic fl,
                       input logic [4:0] r0, input logic [4:0] r1,
                       input logic [31:0] d0, input logic [31:0] d1);
      logic [1:0] exp_rdy;
      int         g;
      exp_t       e;
      @(negedge clk);
      src_valid = v; flush = fl; src_rd = {r1, r0}; src_data = {d1, d0};
      #1;
      exp_rdy = 2'b00;
      g = -1;
      if (!fl) begin
         for (int i = 1; i <= NS; i++) begin
            if (g < 0 && v[(m_last + i) % NS]) g = (m_last + i) % NS;
         end
      end
      if (g >= 0) begin
         exp_rdy[g] = 1'b1;
         e.we    = ((g == 0) ? r0 : r1) != 5'd0;
         e.waddr = (g == 0) ? r0 : r1;
         e.wdata = (g == 0) ? d0 : d1;
         e.gid   = 2'(g);
         sb.push_back(e);
         m_last = g;
         m_count++;
      end
      chk({tag, "_ready"}, src_ready, exp_rdy);
      @(posedge clk); #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "_we"}, rf_we, e.we);
         chk({tag, "_waddr"}, rf_waddr, e.waddr);
         chk({tag, "_wdata"}, rf_wdata, e.wdata);
         chk({tag, "_gid"}, grant_id, e.gid);
      end else begin
         chk({tag, "_idle_we"}, rf_we, 1'b0);
      end
      chk({tag, "_count"}, wb_count, 32'(m_count));
   endtask

   initial begin
      n_pass = 0; n_total = 0; m_last = NS - 1; m_count = 0;
      rst = 1'b1; flush = 1'b0; src_valid = 2'b00; src_rd = '0; src_data = '0;

      do_reset(2, 2'b00);
      for (int i = 0; i < 5; i++) step("idle", 2'b00, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0);

      step("single", 2'b01, 1'b0, 5'd5, 5'd9, 32'hDEADBEEF, 32'h0BADF00D);
      chk("single_gid_const", grant_id, 2'd0);
      step("single_idle", 2'b00, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0);
      chk("rf_x5", rf_mem[5], 32'hDEADBEEF);

      do_reset(1, 2'b11);
      for (int i = 0; i < 6; i++) begin
         step("contend", 2'b11, 1'b0, 5'd1, 5'd2, 32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i));
         chk("contend_gid_seq", grant_id, 2'(i % 2));
         chk("contend_addr_seq", rf_waddr, 5'((i % 2) + 1));
      end
      chk("contend_count6", wb_count, 32'd6);

      step("x0drop", 2'b10, 1'b0, 5'd7, 5'd0, 32'h0, 32'h1234);
      chk("x0_we_const", rf_we, 1'b0);
      chk("x0_count7", wb_count, 32'd7);

      step("pre_flush", 2'b01, 1'b0, 5'd7, 5'd8, 32'h77, 32'h88);
      for (int i = 0; i < 3; i++) step("flush", 2'b11, 1'b1, 5'd7, 5'd8, 32'h77, 32'h88);
      step("post_flush", 2'b11, 1'b0, 5'd7, 5'd8, 32'h77, 32'h88);
      chk("post_flush_gid", grant_id, 2'd1);

      step("pre_rst", 2'b01, 1'b0, 5'd10, 5'd11, 32'hC0, 32'hC1);
      do_reset(1, 2'b10);
      step("after_rst", 2'b11, 1'b0, 5'd12, 5'd13, 32'hD0, 32'hD1);
      chk("after_rst_gid", grant_id, 2'd0);
      chk("after_rst_count", wb_count, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 32x32 register file among NUM_SRC writeback sources (e.g. source 0 = ALU, source 1 = load/store unit).
- Each source presents a valid/ready writeback request. The arbiter grants at most one per cycle using round-robin priority.
- The granted write is registered and driven onto the register file's WriteEnable/WritePort/WriteData.
- Sits between the execute/memory stages and the register file; also keeps an accepted-writeback counter for debug.

Parameters:
- NUM_SRC, 2, number of writeback requesters (2..4)
- ADDR_W, 5, register index width
- DATA_W, 32, write data width
- CNT_W, 32, width of the accepted-writeback counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  when high, no grants this cycle; all src_ready low
- src_valid  in  NUM_SRC  per-source request valid
- src_rd  in  NUM_SRC*ADDR_W  per-source destination register; source i occupies bits [i*ADDR_W +: ADDR_W]
- src_data  in  NUM_SRC*DATA_W  per-source write data, packed the same way
- src_ready  out  NUM_SRC  one-hot-or-zero grant; a transfer occurs when src_valid[i] and src_ready[i] are both high
- rf_we  out  1  to register file WriteEnable
- rf_waddr  out  ADDR_W  to register file WritePort
- rf_wdata  out  DATA_W  to register file WriteData
- grant_id  out  2  index of the source whose write is currently on rf_* (valid when rf_we is high)
- wb_count  out  CNT_W  number of accepted writebacks, including dropped x0 writes

Behaviour:
- Reset, sampled on the rising clk edge while rst is high:
  - rf_we=0, rf_waddr=0, rf_wdata=0, grant_id=0, wb_count=0.
  - Priority pointer last_grant=NUM_SRC-1, so source 0 has highest priority first.
  - rst overrides flush and all requests.
  - src_ready is forced to 0 while rst is high.
- Arbitration (combinational within the cycle):
  - Search the sources in order last_grant+1, last_grant+2, … modulo NUM_SRC. The first source with src_valid set gets src_ready=1; all others get 0.
  - No valid source, or flush high: src_ready all 0.
  - src_ready depends only on src_valid, last_grant, flush and rst. It never depends on src_rd or src_data.
- On the rising edge with a transfer from source g:
  - last_grant<=g.
  - wb_count<=wb_count+1, wrapping modulo 2^CNT_W.
  - rf_waddr<=src_rd[g], rf_wdata<=src_data[g], grant_id<=g.
  - rf_we<=1 if src_rd[g]!=0, else 0. An x0 write is consumed and counted but never written.
- On the rising edge with no transfer:
  - rf_we<=0.
  - rf_waddr, rf_wdata and grant_id hold their previous values.
  - last_grant is unchanged.
- Latency:
  - Handshake at edge N puts rf_we high during cycle N+1.
  - The register file captures the data at edge N+1.
  - Throughput is one write per cycle.
- Fairness: under continuous valid from all sources, grants rotate strictly 0,1,…,NUM_SRC-1,0,… No source waits more than NUM_SRC-1 cycles.
- Sources must hold src_valid, src_rd and src_data stable until accepted. The arbiter does not check this.
- Same rd requested by two sources in one cycle: round-robin order decides. Program-order preservation is the issue stage's responsibility.
- flush asserted mid-stream:
  - A write already registered on rf_* still completes its cycle.
  - No new grant while flush is high.
  - last_grant is preserved.
- Reset mid-operation: any registered-but-not-yet-written request is discarded. rf_we is 0 in the cycle after reset.

Decomposition:
- Shared package: ADDR_W, DATA_W and the zero-register constant (index 0) used by both the register file and the arbiter.
- One natural sub-module: rr_pick, a combinational round-robin priority picker.
  - Inputs: req vector and last_grant.
  - Outputs: one-hot grant and its index.
  - It is reusable for other shared resources.
- The registered output stage and counter stay in regfile_wb_arbiter.

Test Plan:
- Reset then idle: rst high 2 cycles, all valids 0 → rf_we=0, wb_count=0, src_ready=00 for 5 cycles.
- Single source: src_valid=01, rd=5, data=0xDEADBEEF → src_ready=01 same cycle. Next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, grant_id=0, wb_count=1. A later read of x5 from the register file returns 0xDEADBEEF.
- Contention: both valid continuously for 6 cycles (rd 1 and 2) → grants 0,1,0,1,0,1; rf_waddr sequence 1,2,1,2,1,2; wb_count=6.
- x0 drop: source 1 valid with rd=0, data=0x1234 → src_ready=10; next cycle rf_we=0; wb_count increments by 1.
- Flush: both valid with flush high for 3 cycles → src_ready=00, rf_we=0. After flush drops, the grant goes to the source after the last granted one.
- Reset mid-operation: grant at edge N with rst high at edge N+1 → rf_we=0 after N+1, wb_count=0, next grant goes to source 0.
